fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Datapath stage that executes the fetch and PC control lines issued by the control decoder, and supplies the decoder's `instruction` input.
- Holds the program counter (PC) and the 16-bit instruction register (IR).
- Drives the PC onto the address bus and assembles each instruction from two byte reads.
- Tracks fetch sequencing, so the decoder and debug logic can see when a complete instruction is held and when the control sequence was malformed.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- HIST_DEPTH, 4, entries in the branch-history buffer (power of two; used only when FETCH_BRANCH_HIST_EN is defined).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_read  in  1  drive PC onto abus.
- pc_readplusone  in  1  drive PC+1 onto abus.
- pc_readplusfour  in  1  drive PC+4 onto dbus (return address).
- pc_write  in  1  PC <= dbus.
- pc_offset  in  1  PC <= PC + sign-extended dbus[11:0].
- pc_inc  in  1  PC <= PC + 2.
- ir_write  in  1  IR[7:0] <= dbus[7:0].
- ir_writeu  in  1  IR[15:8] <= dbus[7:0].
- abus  out  16  address bus; high-Z when not driving.
- dbus  inout  16  data bus; driven only for pc_readplusfour, otherwise high-Z.
- instruction  out  16  IR contents, to the decoder.
- pc  out  16  current PC (debug/observe).
- instr_valid  out  1  IR holds a complete instruction.
- seq_error  out  1  sticky fetch-sequence / bus-conflict error.

Behaviour:
- Control lines change on the falling clock edge. This block samples them on the rising edge, so they are stable for a half cycle.
- Bus drive is combinational from the control lines (zero latency):
  - abus = PC if pc_read.
  - else abus = PC+1 if pc_readplusone.
  - else abus = 16'hzzzz.
  - dbus = PC+4 if pc_readplusfour, else 16'hzzzz.
- All PC arithmetic is modulo 2^16; 16'hFFFF+1 = 16'h0000 and 16'hFFFE+2 = 16'h0000.
- PC update priority on the rising edge: pc_write > pc_offset > pc_inc > hold.
  - pc_offset adds {{4{dbus[11]}}, dbus[11:0]} to the current PC.
  - The lower-priority request is dropped and seq_error is set when more than one update is requested.
- pc_read together with pc_readplusone: abus = PC and seq_error is set.
- IR byte loads: each asserted ir_write / ir_writeu loads its byte from dbus[7:0] on the rising edge. When both are asserted, both bytes load the same value.
- Fetch FSM, state held in 2 bits:
  - EMPTY: ir_write -> LOW; ir_writeu alone -> EMPTY and set seq_error; both -> FULL.
  - LOW: ir_writeu -> FULL; ir_write -> LOW (low byte reloaded); both -> FULL.
  - FULL: ir_write -> LOW; ir_writeu alone -> EMPTY and set seq_error; both -> FULL.
  - instr_valid = (state == FULL), registered.
  - PC updates do not change FSM state.
- seq_error stays set until reset.
- Reset asserted (reset == 0), including mid-fetch:
  - PC = RESET_VECTOR, IR = 16'h0000, state = EMPTY.
  - instr_valid = 0, seq_error = 0.
  - abus and dbus follow the combinational rules above (high-Z while controls are low).
  - Reset dominates any simultaneous control line.

Optional Feature:
- Macro: FETCH_BRANCH_HIST_EN.
- Defined:
  - Adds ports hist_sel (in, log2(HIST_DEPTH)), hist_data (out, 16) and hist_count (out, log2(HIST_DEPTH)+1).
  - On every accepted pc_write or pc_offset, the pre-update PC is pushed into a HIST_DEPTH-entry circular buffer.
  - Write pointer wraps; when full, the oldest entry is overwritten.
  - hist_count saturates at HIST_DEPTH.
  - hist_data = entry at (wptr-1-hist_sel) mod HIST_DEPTH, combinational; hist_sel 0 returns the most recent entry.
  - Entries beyond hist_count read 16'h0000.
  - Reset clears all entries, the pointer and the count.
- Not defined: no extra ports or logic; all other behaviour is identical.

Test Plan:
- Reset release, then pc_read for 1 cycle -> abus = RESET_VECTOR (16'h0000); all other outputs 0 or high-Z.
- Fetch sequence with PC=16'h0010:
  - pc_read+ir_write with dbus[7:0]=8'h50, then pc_readplusone+ir_writeu with dbus[7:0]=8'h03.
  - Required: abus 16'h0010 then 16'h0011; instruction=16'h0350; instr_valid=1 after 2nd edge; seq_error=0.
- PC arithmetic:
  - PC=16'hFFFE with pc_inc -> PC=16'h0000.
  - PC=16'h0100, pc_offset, dbus=16'h0FFC -> PC=16'h00FC.
  - pc_readplusfour with PC=16'h0020 -> dbus=16'h0024.
- Conflicts:
  - pc_write (dbus=16'h1234) + pc_inc together -> PC=16'h1234, seq_error=1.
  - Lone ir_writeu from EMPTY -> seq_error=1, instr_valid=0.
- Reset mid-fetch: assert reset in LOW state -> PC=RESET_VECTOR, IR=0, instr_valid=0, seq_error cleared, asynchronously (no clock edge needed).
- FETCH_BRANCH_HIST_EN: 5 pc_write branches from PCs 1,2,3,4,5 -> hist_count=4; hist_sel 0..3 -> 5,4,3,2.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: holds PC and IR, drives the address/data buses and tracks fetch sequencing.
// Optional branch-history buffer enabled by defining FETCH_BRANCH_HIST_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          HIST_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_read,
  input  logic        pc_readplusone,
  input  logic        pc_readplusfour,
  input  logic        pc_write,
  input  logic        pc_offset,
  input  logic        pc_inc,
  input  logic        ir_write,
  input  logic        ir_writeu,
`ifdef FETCH_BRANCH_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_sel,
  output logic [15:0]                   hist_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
`endif
  output logic [15:0] abus,
  inout  wire  [15:0] dbus,
  output logic [15:0] instruction,
  output logic [15:0] pc,
  output logic        instr_valid,
  output logic        seq_error
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  fetch_state_t state_q, state_d;

  logic [15:0]        pc_q, pc_d;
  logic [15:0]        ir_q;
  logic               instr_valid_q;
  logic               seq_error_q, seq_error_d;
  logic               upd_conflict;
  logic               read_conflict;
  logic               byte_err;
  logic signed [15:0] offset_s;
  logic [15:0]        pc_plus1;
  logic [15:0]        pc_plus4;

  function automatic logic signed [15:0] sext12(input logic [11:0] v);
    return signed'({{4{v[11]}}, v});
  endfunction

  assign pc_plus1 = pc_q + 16'd1;
  assign pc_plus4 = pc_q + 16'd4;

  // Bus drive is purely combinational from the control lines; pc_read wins over pc_readplusone.
  assign abus = pc_read ? pc_q : (pc_readplusone ? pc_plus1 : 16'hzzzz);
  assign dbus = pc_readplusfour ? pc_plus4 : 16'hzzzz;

  assign offset_s      = sext12(dbus[11:0]);
  assign upd_conflict  = (pc_write & (pc_offset | pc_inc)) | (pc_offset & pc_inc);
  assign read_conflict = pc_read & pc_readplusone;

  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = dbus;
    end else if (pc_offset) begin
      pc_d = 16'(signed'(pc_q) + offset_s);
    end else if (pc_inc) begin
      pc_d = pc_q + 16'd2;
    end
  end

  always_comb begin
    state_d  = state_q;
    byte_err = 1'b0;
    case (state_q)
      EMPTY, FULL: begin
        if (ir_write) begin
          state_d = ir_writeu ? FULL : LOW;
        end else if (ir_writeu) begin
          state_d  = EMPTY;
          byte_err = 1'b1;
        end
      end
      LOW: begin
        if (ir_writeu) begin
          state_d = FULL;
        end else if (ir_write) begin
          state_d = LOW;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign seq_error_d = seq_error_q | upd_conflict | read_conflict | byte_err;

  // Rising-edge state update; reset also clears PC and IR so a restarted fetch is clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VECTOR;
      ir_q          <= 16'h0000;
      state_q       <= EMPTY;
      instr_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (ir_write) begin
        ir_q[7:0] <= dbus[7:0];
      end
      if (ir_writeu) begin
        ir_q[15:8] <= dbus[7:0];
      end
      state_q       <= state_d;
      instr_valid_q <= (state_d == FULL);
      seq_error_q   <= seq_error_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = ir_q;
  assign instr_valid = instr_valid_q;
  assign seq_error   = seq_error_q;

`ifdef FETCH_BRANCH_HIST_EN
  localparam int HW = $clog2(HIST_DEPTH);
  localparam logic [HW:0] HIST_FULL = (HW+1)'(HIST_DEPTH);

  logic [15:0]   hist_mem [HIST_DEPTH];
  logic [HW-1:0] hist_wptr;
  logic [HW:0]   hist_cnt;
  logic [HW-1:0] hist_rd;
  logic          branch_taken;

  assign branch_taken = pc_write | pc_offset;

  // Circular buffer of pre-branch PCs; the oldest entry is overwritten once full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_mem[i] <= 16'h0000;
      end
      hist_wptr <= '0;
      hist_cnt  <= '0;
    end else if (branch_taken) begin
      hist_mem[hist_wptr] <= pc_q;
      hist_wptr           <= hist_wptr + HW'(1);
      if (hist_cnt != HIST_FULL) begin
        hist_cnt <= hist_cnt + (HW+1)'(1);
      end
    end
  end

  assign hist_rd = hist_wptr - HW'(1) - hist_sel;

  always_comb begin
    hist_data = 16'h0000;
    if ({1'b0, hist_sel} < hist_cnt) begin
      hist_data = hist_mem[hist_rd];
    end
  end

  assign hist_count = hist_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [7:0] R  = 8'h80;
  localparam logic [7:0] R1 = 8'h40;
  localparam logic [7:0] R4 = 8'h20;
  localparam logic [7:0] W  = 8'h10;
  localparam logic [7:0] O  = 8'h08;
  localparam logic [7:0] I  = 8'h04;
  localparam logic [7:0] IW = 8'h02;
  localparam logic [7:0] IU = 8'h01;

  localparam int S_ABUS  = 0;
  localparam int S_DBUS  = 1;
  localparam int S_IR    = 2;
  localparam int S_PC    = 3;
  localparam int S_VLD   = 4;
  localparam int S_ERR   = 5;
  localparam int S_HDATA = 6;
  localparam int S_HCNT  = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pc_read = 1'b0, pc_readplusone = 1'b0, pc_readplusfour = 1'b0;
  logic pc_write = 1'b0, pc_offset = 1'b0, pc_inc = 1'b0;
  logic ir_write = 1'b0, ir_writeu = 1'b0;
  logic [15:0] dbus_drv = 16'h0000;
  logic dbus_en = 1'b0;

  wire [15:0] abus;
  wire [15:0] dbus;
  wire [15:0] instruction;
  wire [15:0] pc;
  wire        instr_valid;
  wire        seq_error;

  assign dbus = dbus_en ? dbus_drv : 16'hzzzz;

`ifdef FETCH_BRANCH_HIST_EN
  logic [1:0] hist_sel = 2'd0;
  wire [15:0] hist_data;
  wire [2:0]  hist_count;
`endif

  fetch_unit #(.RESET_VECTOR(16'h0000), .HIST_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .pc_read(pc_read),
    .pc_readplusone(pc_readplusone),
    .pc_readplusfour(pc_readplusfour),
    .pc_write(pc_write),
    .pc_offset(pc_offset),
    .pc_inc(pc_inc),
    .ir_write(ir_write),
    .ir_writeu(ir_writeu),
`ifdef FETCH_BRANCH_HIST_EN
    .hist_sel(hist_sel),
    .hist_data(hist_data),
    .hist_count(hist_count),
`endif
    .abus(abus),
    .dbus(dbus),
    .instruction(instruction),
    .pc(pc),
    .instr_valid(instr_valid),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      due;
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] sample(input int sig);
    case (sig)
      S_ABUS: return abus;
      S_DBUS: return dbus;
      S_IR:   return instruction;
      S_PC:   return pc;
      S_VLD:  return {15'd0, instr_valid};
      S_ERR:  return {15'd0, seq_error};
`ifdef FETCH_BRANCH_HIST_EN
      S_HDATA: return hist_data;
      S_HCNT:  return {13'd0, hist_count};
`endif
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_at(input int dt, input int sig, input logic [15:0] v, input string nm);
    exp_t e;
    e.due  = longint'($time) + longint'(dt);
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due <= longint'($time)) begin
          logic [15:0] got;
          got = sample(q[i].sig);
          checks++;
          if (got !== q[i].exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", q[i].name, got, q[i].exp, $time);
          end
          q.delete(i);
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] ctl, input logic [15:0] d, input bit den);
    @(negedge clk);
    {pc_read, pc_readplusone, pc_readplusfour, pc_write, pc_offset, pc_inc, ir_write, ir_writeu} = ctl;
    dbus_drv = d;
    dbus_en  = den;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    reset = 1'b0;
    expect_at(1, S_PC,  16'h0000, {nm, "_pc"});
    expect_at(1, S_IR,  16'h0000, {nm, "_ir"});
    expect_at(1, S_VLD, 16'h0000, {nm, "_vld"});
    expect_at(1, S_ERR, 16'h0000, {nm, "_err"});
    expect_at(4, S_IR,  16'h0000, {nm, "_ir_hold"});
    expect_at(4, S_PC,  16'h0000, {nm, "_pc_hold"});
    @(negedge clk);
    {pc_read, pc_readplusone, pc_readplusfour, pc_write, pc_offset, pc_inc, ir_write, ir_writeu} = 8'h00;
    dbus_en = 1'b0;
    reset   = 1'b1;
  endtask

  initial begin
    expect_at(3, S_PC,  16'h0000, "por_pc");
    expect_at(3, S_IR,  16'h0000, "por_ir");
    expect_at(3, S_VLD, 16'h0000, "por_vld");
    expect_at(3, S_ERR, 16'h0000, "por_err");
    @(negedge clk);
    reset = 1'b1;

    cyc(R, 16'h0000, 1'b0);
    expect_at(4, S_ABUS, 16'h0000, "rd_reset_vector");
    expect_at(6, S_PC,   16'h0000, "pc_hold");

    cyc(W, 16'h0010, 1'b1);
    expect_at(6, S_PC, 16'h0010, "pc_write");

    cyc(R | IW, 16'h0050, 1'b1);
    expect_at(4, S_ABUS, 16'h0010, "fetch_abus_lo");
    expect_at(6, S_IR,   16'h0050, "fetch_ir_lo");
    expect_at(6, S_VLD,  16'h0000, "fetch_vld_lo");

    cyc(R1 | IU, 16'h0003, 1'b1);
    expect_at(4, S_ABUS, 16'h0011, "fetch_abus_hi");
    expect_at(6, S_IR,   16'h0350, "fetch_ir_full");
    expect_at(6, S_VLD,  16'h0001, "fetch_vld_full");
    expect_at(6, S_ERR,  16'h0000, "fetch_err");

    cyc(IW | IU, 16'h00A5, 1'b1);
    expect_at(6, S_IR,  16'hA5A5, "both_bytes_ir");
    expect_at(6, S_VLD, 16'h0001, "both_bytes_vld");

    cyc(IW, 16'h0011, 1'b1);
    expect_at(6, S_IR,  16'hA511, "full_to_low_ir");
    expect_at(6, S_VLD, 16'h0000, "full_to_low_vld");

    cyc(IW, 16'h0022, 1'b1);
    expect_at(6, S_IR,  16'hA522, "low_reload_ir");
    expect_at(6, S_VLD, 16'h0000, "low_reload_vld");

    cyc(IU, 16'h0033, 1'b1);
    expect_at(6, S_IR,  16'h3322, "low_to_full_ir");
    expect_at(6, S_VLD, 16'h0001, "low_to_full_vld");
    expect_at(6, S_ERR, 16'h0000, "low_to_full_err");

    cyc(W, 16'hFFFE, 1'b1);
    cyc(I, 16'h0000, 1'b0);
    expect_at(6, S_PC, 16'h0000, "inc_wrap");

    cyc(W, 16'hFFFF, 1'b1);
    cyc(R1, 16'h0000, 1'b0);
    expect_at(4, S_ABUS, 16'h0000, "plusone_wrap");

    cyc(W, 16'h0100, 1'b1);
    cyc(O, 16'h0FFC, 1'b1);
    expect_at(6, S_PC, 16'h00FC, "offset_neg");

    cyc(O, 16'hF005, 1'b1);
    expect_at(6, S_PC, 16'h0101, "offset_pos_upper_ignored");

    cyc(W, 16'h0020, 1'b1);
    cyc(R4, 16'h0000, 1'b0);
    expect_at(4, S_DBUS, 16'h0024, "plusfour_dbus");
    expect_at(6, S_PC,   16'h0020, "plusfour_pc_hold");
    expect_at(6, S_ERR,  16'h0000, "clean_err");

    cyc(W | I, 16'h1234, 1'b1);
    expect_at(6, S_PC,  16'h1234, "write_inc_pc");
    expect_at(6, S_ERR, 16'h0001, "write_inc_err");

    cyc(8'h00, 16'h0000, 1'b0);
    expect_at(6, S_ERR, 16'h0001, "err_sticky");

    do_reset("rst1");

    cyc(IU, 16'h0077, 1'b1);
    expect_at(6, S_IR,  16'h7700, "lone_upper_ir");
    expect_at(6, S_ERR, 16'h0001, "lone_upper_err");
    expect_at(6, S_VLD, 16'h0000, "lone_upper_vld");

    do_reset("rst2");

    cyc(W, 16'h0040, 1'b1);
    cyc(R | R1, 16'h0000, 1'b0);
    expect_at(4, S_ABUS, 16'h0040, "dual_read_abus");
    expect_at(6, S_ERR,  16'h0001, "dual_read_err");

    do_reset("rst3");

    cyc(W, 16'h0055, 1'b1);
    cyc(O | I, 16'h0002, 1'b1);
    expect_at(6, S_PC,  16'h0057, "offset_inc_pc");
    expect_at(6, S_ERR, 16'h0001, "offset_inc_err");
    cyc(IW, 16'h003C, 1'b1);
    expect_at(6, S_IR,  16'h003C, "midfetch_ir");
    expect_at(6, S_VLD, 16'h0000, "midfetch_vld");

    do_reset("rst_midfetch");

    #1;
    checks++;
    if (pc !== 16'h0000) begin
      failures++;
      $display("FAIL post_reset_pc: got %h", pc);
    end
    checks++;
    if (instruction !== 16'h0000) begin
      failures++;
      $display("FAIL post_reset_ir: got %h", instruction);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_vld: got %b", instr_valid);
    end
    checks++;
    if (seq_error !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_err: got %b", seq_error);
    end
    checks++;
    if (abus !== 16'hzzzz) begin
      failures++;
      $display("FAIL post_reset_abus: got %h", abus);
    end

`ifdef FETCH_BRANCH_HIST_EN
    expect_at(3, S_HCNT, 16'h0000, "hist_cnt_reset");
    cyc(W, 16'h0001, 1'b1);
    cyc(W, 16'h0002, 1'b1);
    expect_at(6, S_HCNT, 16'h0002, "hist_cnt_two");
    cyc(8'h00, 16'h0000, 1'b0);
    hist_sel = 2'd0;
    expect_at(4, S_HDATA, 16'h0001, "hist_partial_sel0");
    cyc(8'h00, 16'h0000, 1'b0);
    hist_sel = 2'd2;
    expect_at(4, S_HDATA, 16'h0000, "hist_beyond_count");
    cyc(W, 16'h0003, 1'b1);
    cyc(W, 16'h0004, 1'b1);
    cyc(W, 16'h0005, 1'b1);
    cyc(W, 16'h0006, 1'b1);
    expect_at(6, S_HCNT, 16'h0004, "hist_cnt_sat");
    for (int s = 0; s < 4; s++) begin
      cyc(8'h00, 16'h0000, 1'b0);
      hist_sel = 2'(s);
      expect_at(4, S_HDATA, 16'(5 - s), $sformatf("hist_sel%0d", s));
    end
`endif

    cyc(8'h00, 16'h0000, 1'b0);
    for (int k = 0; k < 50 && q.size() > 0; k++) begin
      @(posedge clk);
    end
    while (q.size() > 0) begin
      failures++;
      $display("FAIL %s: never sampled, expected %h", q[0].name, q[0].exp);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
